// File: rtl/param_set_assoc_dcache.sv
// Write-back, write-allocate, N-way set-associative data cache with true-LRU
// replacement, whole-cache flush and saturating hit/miss counters.
module param_set_assoc_dcache #(
    parameter int ADDR_W          = 8,
    parameter int DATA_W          = 8,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int SETS            = 8,
    parameter int WAYS            = 2,
    parameter int CNT_W           = 16,
    localparam int OFF_W          = $clog2(WORDS_PER_BLOCK),
    localparam int IDX_W          = $clog2(SETS),
    localparam int TAG_W          = ADDR_W - IDX_W - OFF_W,
    localparam int BLK_W          = DATA_W * WORDS_PER_BLOCK
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    READ,
    input  logic                    WRITE,
    input  logic [ADDR_W-1:0]       ADDRESS,
    input  logic [DATA_W-1:0]       WRITEDATA,
    output logic [DATA_W-1:0]       READDATA,
    output logic                    BUSYWAIT,
    input  logic                    FLUSH,
    output logic                    FLUSH_DONE,
    output logic                    MEM_READ,
    output logic                    MEM_WRITE,
    output logic [ADDR_W-OFF_W-1:0] MEM_ADDRESS,
    output logic [BLK_W-1:0]        MEM_WRITEDATA,
    input  logic [BLK_W-1:0]        MEM_READDATA,
    input  logic                    MEM_BUSYWAIT,
    output logic [CNT_W-1:0]        HIT_COUNT,
    output logic [CNT_W-1:0]        MISS_COUNT
);

    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        UPDATE,
        FLUSH_SCAN,
        FLUSH_WB
    } state_t;

    state_t state_q;

    logic             valid_q [SETS][WAYS];
    logic             dirty_q [SETS][WAYS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [BLK_W-1:0] data_q  [SETS][WAYS];
    // Row w, bit v set means way w was used more recently than way v.
    logic [WAYS-1:0]  lru_q   [SETS][WAYS];

    logic [TAG_W-1:0] miss_tag_q;
    logic [IDX_W-1:0] miss_idx_q;
    logic [WAY_W-1:0] victim_q;
    logic [IDX_W-1:0] scan_set_q;
    logic [WAY_W-1:0] scan_way_q;

    logic              req;
    logic              is_write;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  victim;
    logic              victim_found;
    logic              scan_last;

    assign req      = READ | WRITE;
    assign is_write = WRITE;
    assign req_tag  = ADDRESS[ADDR_W-1 -: TAG_W];
    assign req_idx  = ADDRESS[OFF_W +: IDX_W];
    assign req_off  = ADDRESS[OFF_W-1:0];

    assign scan_last = (scan_set_q == IDX_W'(SETS - 1)) && (scan_way_q == WAY_W'(WAYS - 1));

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Invalid ways are filled lowest-first; otherwise the way whose LRU row is empty is oldest.
    always_comb begin
        victim       = '0;
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid_q[req_idx][w]) begin
                victim       = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && (lru_q[req_idx][w] == '0)) begin
                victim       = WAY_W'(w);
                victim_found = 1'b1;
            end
        end
    end

    assign BUSYWAIT = RESET & req & ~((state_q == IDLE) & hit);
    assign READDATA = ((state_q == IDLE) && hit && READ && !WRITE)
                    ? data_q[req_idx][hit_way][int'(req_off)*DATA_W +: DATA_W]
                    : '0;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= IDLE;
            HIT_COUNT     <= '0;
            MISS_COUNT    <= '0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            FLUSH_DONE    <= 1'b0;
            miss_tag_q    <= '0;
            miss_idx_q    <= '0;
            victim_q      <= '0;
            scan_set_q    <= '0;
            scan_way_q    <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    lru_q[s][w]   <= '0;
                end
            end
        end else begin
            FLUSH_DONE <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req && hit) begin
                        if (HIT_COUNT != '1) HIT_COUNT <= HIT_COUNT + 1'b1;
                        if (is_write) dirty_q[req_idx][hit_way] <= 1'b1;
                        for (int v = 0; v < WAYS; v++) begin
                            lru_q[req_idx][hit_way][v] <= (v != int'(hit_way));
                            if (v != int'(hit_way)) lru_q[req_idx][v][hit_way] <= 1'b0;
                        end
                    end else if (req) begin
                        if (MISS_COUNT != '1) MISS_COUNT <= MISS_COUNT + 1'b1;
                        miss_tag_q <= req_tag;
                        miss_idx_q <= req_idx;
                        victim_q   <= victim;
                        if (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) begin
                            state_q       <= WRITEBACK;
                            MEM_WRITE     <= 1'b1;
                            MEM_ADDRESS   <= {tag_q[req_idx][victim], req_idx};
                            MEM_WRITEDATA <= data_q[req_idx][victim];
                        end else begin
                            state_q     <= ALLOCATE;
                            MEM_READ    <= 1'b1;
                            MEM_ADDRESS <= {req_tag, req_idx};
                        end
                    end else if (FLUSH) begin
                        state_q    <= FLUSH_SCAN;
                        scan_set_q <= '0;
                        scan_way_q <= '0;
                    end
                end

                WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        state_q     <= ALLOCATE;
                        MEM_WRITE   <= 1'b0;
                        MEM_READ    <= 1'b1;
                        MEM_ADDRESS <= {miss_tag_q, miss_idx_q};
                    end
                end

                ALLOCATE: begin
                    if (!MEM_BUSYWAIT) begin
                        state_q                       <= UPDATE;
                        MEM_READ                      <= 1'b0;
                        valid_q[miss_idx_q][victim_q] <= 1'b1;
                        dirty_q[miss_idx_q][victim_q] <= 1'b0;
                        tag_q[miss_idx_q][victim_q]   <= miss_tag_q;
                    end
                end

                UPDATE: state_q <= IDLE;

                // A written-back line comes back here clean and then costs one more scan cycle.
                FLUSH_SCAN: begin
                    if (valid_q[scan_set_q][scan_way_q] && dirty_q[scan_set_q][scan_way_q]) begin
                        state_q       <= FLUSH_WB;
                        MEM_WRITE     <= 1'b1;
                        MEM_ADDRESS   <= {tag_q[scan_set_q][scan_way_q], scan_set_q};
                        MEM_WRITEDATA <= data_q[scan_set_q][scan_way_q];
                    end else if (scan_last) begin
                        state_q    <= IDLE;
                        FLUSH_DONE <= 1'b1;
                    end else if (scan_way_q == WAY_W'(WAYS - 1)) begin
                        scan_way_q <= '0;
                        scan_set_q <= scan_set_q + 1'b1;
                    end else begin
                        scan_way_q <= scan_way_q + 1'b1;
                    end
                end

                FLUSH_WB: begin
                    if (!MEM_BUSYWAIT) begin
                        state_q                         <= FLUSH_SCAN;
                        MEM_WRITE                       <= 1'b0;
                        dirty_q[scan_set_q][scan_way_q] <= 1'b0;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    // Line data carries no reset; reset parks the FSM in IDLE with all lines invalid.
    always_ff @(posedge CLK) begin
        if ((state_q == IDLE) && req && hit && is_write) begin
            data_q[req_idx][hit_way][int'(req_off)*DATA_W +: DATA_W] <= WRITEDATA;
        end else if ((state_q == ALLOCATE) && !MEM_BUSYWAIT) begin
            data_q[miss_idx_q][victim_q] <= MEM_READDATA;
        end
    end

endmodule

// File: tb/tb_param_set_assoc_dcache.sv
// Directed bench for param_set_assoc_dcache: default 2-way cache plus a
// direct-mapped 16-set build with 2-bit counters, each on its own memory model.
module tb_param_set_assoc_dcache;

    localparam int LAT = 5;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    logic        read, write, flush;
    logic [7:0]  address, writedata, readdata;
    logic        busywait, flush_done, mem_read, mem_write, mem_busywait;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic [15:0] hit_count, miss_count;

    logic        dm_read, dm_write, dm_flush;
    logic [7:0]  dm_address, dm_writedata, dm_readdata;
    logic        dm_busywait, dm_flush_done, dm_mem_read, dm_mem_write, dm_mem_busywait;
    logic [5:0]  dm_mem_address;
    logic [31:0] dm_mem_writedata, dm_mem_readdata;
    logic [1:0]  dm_hit_count, dm_miss_count;

    param_set_assoc_dcache dut (
        .CLK(CLK), .RESET(RESET), .READ(read), .WRITE(write), .ADDRESS(address),
        .WRITEDATA(writedata), .READDATA(readdata), .BUSYWAIT(busywait), .FLUSH(flush),
        .FLUSH_DONE(flush_done), .MEM_READ(mem_read), .MEM_WRITE(mem_write),
        .MEM_ADDRESS(mem_address), .MEM_WRITEDATA(mem_writedata), .MEM_READDATA(mem_readdata),
        .MEM_BUSYWAIT(mem_busywait), .HIT_COUNT(hit_count), .MISS_COUNT(miss_count)
    );

    param_set_assoc_dcache #(.SETS(16), .WAYS(1), .CNT_W(2)) dut_dm (
        .CLK(CLK), .RESET(RESET), .READ(dm_read), .WRITE(dm_write), .ADDRESS(dm_address),
        .WRITEDATA(dm_writedata), .READDATA(dm_readdata), .BUSYWAIT(dm_busywait), .FLUSH(dm_flush),
        .FLUSH_DONE(dm_flush_done), .MEM_READ(dm_mem_read), .MEM_WRITE(dm_mem_write),
        .MEM_ADDRESS(dm_mem_address), .MEM_WRITEDATA(dm_mem_writedata), .MEM_READDATA(dm_mem_readdata),
        .MEM_BUSYWAIT(dm_mem_busywait), .HIT_COUNT(dm_hit_count), .MISS_COUNT(dm_miss_count)
    );

    int vec_count = 0;
    int miscompares = 0;

    // Memory model A: busy for LAT cycles per new request, byte n holds n after reset.
    logic [7:0]  mem_a [256];
    logic [7:0]  key_a, key_a_q = '0;
    int          cnt_a = 0;
    int          n_txn_a = 0, n_rd_a = 0, n_wr_a = 0;
    logic        txn_is_wr [32];
    logic [5:0]  txn_addr [32];
    logic [31:0] txn_data [32];

    assign key_a = {mem_read, mem_write, mem_address};
    assign mem_busywait = (mem_read | mem_write) && !(cnt_a == LAT && key_a == key_a_q);

    always_comb begin
        mem_readdata = '0;
        for (int i = 0; i < 4; i++) mem_readdata[8*i +: 8] = mem_a[{mem_address, 2'(i)}];
    end

    always @(posedge CLK) begin
        key_a_q <= key_a;
        if (!(mem_read | mem_write) || key_a != key_a_q) cnt_a <= 0;
        else if (cnt_a < LAT) cnt_a <= cnt_a + 1;
        if (mem_write && key_a == key_a_q && cnt_a == LAT - 1)
            for (int i = 0; i < 4; i++) mem_a[{mem_address, 2'(i)}] <= mem_writedata[8*i +: 8];
        if ((mem_read | mem_write) && key_a != key_a_q) begin
            if (n_txn_a < 32) begin
                txn_is_wr[n_txn_a] <= mem_write;
                txn_addr[n_txn_a]  <= mem_address;
                txn_data[n_txn_a]  <= mem_writedata;
            end
            n_txn_a <= n_txn_a + 1;
            if (mem_write) n_wr_a <= n_wr_a + 1;
            else n_rd_a <= n_rd_a + 1;
        end
    end

    // Memory model B for the direct-mapped build.
    logic [7:0] mem_b [256];
    logic [7:0] key_b, key_b_q = '0;
    int         cnt_b = 0;
    int         n_rd_b = 0, n_wr_b = 0;

    assign key_b = {dm_mem_read, dm_mem_write, dm_mem_address};
    assign dm_mem_busywait = (dm_mem_read | dm_mem_write) && !(cnt_b == LAT && key_b == key_b_q);

    always_comb begin
        dm_mem_readdata = '0;
        for (int i = 0; i < 4; i++) dm_mem_readdata[8*i +: 8] = mem_b[{dm_mem_address, 2'(i)}];
    end

    always @(posedge CLK) begin
        key_b_q <= key_b;
        if (!(dm_mem_read | dm_mem_write) || key_b != key_b_q) cnt_b <= 0;
        else if (cnt_b < LAT) cnt_b <= cnt_b + 1;
        if (dm_mem_write && key_b == key_b_q && cnt_b == LAT - 1)
            for (int i = 0; i < 4; i++) mem_b[{dm_mem_address, 2'(i)}] <= dm_mem_writedata[8*i +: 8];
        if ((dm_mem_read | dm_mem_write) && key_b != key_b_q) begin
            if (dm_mem_write) n_wr_b <= n_wr_b + 1;
            else n_rd_b <= n_rd_b + 1;
        end
    end

    int both_high = 0;
    int done_pulses = 0;
    always @(negedge CLK) begin
        if ((mem_read && mem_write) || (dm_mem_read && dm_mem_write)) both_high++;
        if (flush_done) done_pulses++;
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'(i);
            mem_b[i] = 8'(i);
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called just after a rising edge; holds the request until BUSYWAIT drops and returns just after the accepting edge.
    task automatic apply_stimulus(input bit dm, input logic rd, input logic wr, input logic [7:0] a,
                                  input logic [7:0] d, output logic [7:0] rdata, output int stalls);
        stalls = 0;
        if (dm) begin
            dm_read = rd; dm_write = wr; dm_address = a; dm_writedata = d;
        end else begin
            read = rd; write = wr; address = a; writedata = d;
        end
        @(negedge CLK);
        while ((dm ? dm_busywait : busywait) && stalls < 300) begin
            stalls++;
            @(negedge CLK);
        end
        rdata = dm ? dm_readdata : readdata;
        if (stalls >= 300) begin
            vec_count++;
            miscompares++;
            $display("[TB] FAIL access 0x%0h timeout: busywait still 1 after %0d cycles, required 0", a, stalls);
        end
        @(posedge CLK);
        #1;
        read = 0; write = 0; dm_read = 0; dm_write = 0;
    endtask

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_stall;
        int         exp_hits;
        int         exp_misses;
        int         exp_rd;
        int         exp_wr;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [7:0] rdata;
        int         stalls, rd0, wr0, txn0, done0, n;

        vecs[0]  = '{1'b1, 1'b0, 8'h05, 8'h00, 8'h05, 1'b1, 1,  1, 1, 0};
        vecs[1]  = '{1'b0, 1'b1, 8'h05, 8'hAA, 8'h00, 1'b0, 2,  1, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 8'h05, 8'h00, 8'hAA, 1'b0, 3,  1, 0, 0};
        vecs[3]  = '{1'b1, 1'b0, 8'h25, 8'h00, 8'h25, 1'b1, 4,  2, 1, 0};
        vecs[4]  = '{1'b1, 1'b0, 8'h05, 8'h00, 8'hAA, 1'b0, 5,  2, 0, 0};
        vecs[5]  = '{1'b1, 1'b0, 8'h45, 8'h00, 8'h45, 1'b1, 6,  3, 1, 0};
        vecs[6]  = '{1'b1, 1'b0, 8'h25, 8'h00, 8'h25, 1'b1, 7,  4, 1, 1};
        vecs[7]  = '{1'b1, 1'b0, 8'h05, 8'h00, 8'hAA, 1'b1, 8,  5, 1, 0};
        vecs[8]  = '{1'b0, 1'b1, 8'h78, 8'h5C, 8'h00, 1'b1, 9,  6, 1, 0};
        vecs[9]  = '{1'b0, 1'b1, 8'h05, 8'h77, 8'h00, 1'b0, 10, 6, 0, 0};
        vecs[10] = '{1'b1, 1'b0, 8'h7A, 8'h00, 8'h7A, 1'b0, 11, 6, 0, 0};

        read = 0; write = 0; flush = 0; address = 0; writedata = 0;
        dm_read = 0; dm_write = 0; dm_flush = 0; dm_address = 0; dm_writedata = 0;

        repeat (3) @(posedge CLK);
        #1;
        check_output("reset busywait", 32'(busywait), 0);
        check_output("reset mem_read", 32'(mem_read), 0);
        check_output("reset mem_write", 32'(mem_write), 0);
        check_output("reset mem_address", 32'(mem_address), 0);
        check_output("reset flush_done", 32'(flush_done), 0);
        check_output("reset hit_count", 32'(hit_count), 0);
        check_output("reset miss_count", 32'(miss_count), 0);
        check_output("reset readdata", 32'(readdata), 0);
        RESET = 1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 11; i++) begin
            rd0 = n_rd_a;
            wr0 = n_wr_a;
            apply_stimulus(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, stalls);
            check_output($sformatf("v%0d readdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
            check_output($sformatf("v%0d stalled", i), 32'(stalls > 0), 32'(vecs[i].exp_stall));
            check_output($sformatf("v%0d hit_count", i), 32'(hit_count), vecs[i].exp_hits);
            check_output($sformatf("v%0d miss_count", i), 32'(miss_count), vecs[i].exp_misses);
            check_output($sformatf("v%0d mem reads", i), n_rd_a - rd0, vecs[i].exp_rd);
            check_output($sformatf("v%0d mem writes", i), n_wr_a - wr0, vecs[i].exp_wr);
        end

        check_output("cold fill block address", 32'(txn_addr[0]), 32'h01);
        check_output("evict txn3 is write", 32'(txn_is_wr[3]), 1);
        check_output("evict write address", 32'(txn_addr[3]), 32'h01);
        check_output("evict write byte1", 32'(txn_data[3][15:8]), 32'hAA);
        check_output("evict txn4 is read", 32'(txn_is_wr[4]), 0);
        check_output("evict fill address", 32'(txn_addr[4]), 32'h09);

        // Flush with dirty lines in set 1 (block 0x01) and set 6 (block 0x1E).
        txn0  = n_txn_a;
        done0 = done_pulses;
        flush = 1;
        @(posedge CLK);
        #1;
        flush = 0;
        n = 0;
        while (!flush_done && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check_output("flush_done seen", 32'(flush_done), 1);
        repeat (4) @(posedge CLK);
        #1;
        check_output("flush done pulses", done_pulses - done0, 1);
        check_output("flush txn count", n_txn_a - txn0, 2);
        check_output("flush wb0 is write", 32'(txn_is_wr[txn0]), 1);
        check_output("flush wb0 address", 32'(txn_addr[txn0]), 32'h01);
        check_output("flush wb0 byte1", 32'(txn_data[txn0][15:8]), 32'h77);
        check_output("flush wb1 is write", 32'(txn_is_wr[txn0+1]), 1);
        check_output("flush wb1 address", 32'(txn_addr[txn0+1]), 32'h1E);
        check_output("flush wb1 byte0", 32'(txn_data[txn0+1][7:0]), 32'h5C);

        txn0 = n_txn_a;
        apply_stimulus(0, 1, 0, 8'h05, 8'h00, rdata, stalls);
        check_output("post-flush read data", 32'(rdata), 32'h77);
        check_output("post-flush read stalls", stalls, 0);
        check_output("post-flush no traffic", n_txn_a - txn0, 0);
        check_output("post-flush hit_count", 32'(hit_count), 12);
        check_output("post-flush miss_count", 32'(miss_count), 6);

        // Reset asserted in the second cycle of a fill.
        read = 1;
        address = 8'h09;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!mem_read && n < 20);
        check_output("fill started", 32'(mem_read), 1);
        check_output("readdata zero on miss", 32'(readdata), 0);
        @(posedge CLK);
        #1;
        RESET = 0;
        #1;
        check_output("reset drops mem_read", 32'(mem_read), 0);
        check_output("reset busywait", 32'(busywait), 0);
        check_output("reset clears hits", 32'(hit_count), 0);
        check_output("reset clears misses", 32'(miss_count), 0);
        read = 0;
        @(posedge CLK);
        #1;
        RESET = 1;
        @(posedge CLK);
        #1;
        rd0 = n_rd_a;
        apply_stimulus(0, 1, 0, 8'h05, 8'h00, rdata, stalls);
        check_output("after reset read stalls", 32'(stalls > 0), 1);
        check_output("after reset read data", 32'(rdata), 32'h77);
        check_output("after reset miss_count", 32'(miss_count), 1);
        check_output("after reset hit_count", 32'(hit_count), 1);
        check_output("after reset fills", n_rd_a - rd0, 1);

        // Direct-mapped build: 0x05 and 0x45 share set 1, counters saturate at 3.
        rd0 = n_rd_b;
        wr0 = n_wr_b;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] a;
            a = (i % 2 == 0) ? 8'h05 : 8'h45;
            apply_stimulus(1, 1, 0, a, 8'h00, rdata, stalls);
            check_output($sformatf("dm%0d readdata", i), 32'(rdata), 32'(a));
            check_output($sformatf("dm%0d stalled", i), 32'(stalls > 0), 1);
            if (i == 1) begin
                check_output("dm miss_count 2", 32'(dm_miss_count), 2);
                check_output("dm hit_count 2", 32'(dm_hit_count), 2);
            end
        end
        check_output("dm miss_count sat", 32'(dm_miss_count), 3);
        check_output("dm hit_count sat", 32'(dm_hit_count), 3);
        check_output("dm clean fills", n_rd_b - rd0, 5);
        check_output("dm clean no writes", n_wr_b - wr0, 0);

        apply_stimulus(1, 0, 1, 8'h05, 8'h33, rdata, stalls);
        check_output("dm write hit stalls", stalls, 0);
        apply_stimulus(1, 1, 0, 8'h45, 8'h00, rdata, stalls);
        check_output("dm dirty evict writes", n_wr_b - wr0, 1);
        apply_stimulus(1, 1, 0, 8'h05, 8'h00, rdata, stalls);
        check_output("dm written-back data", 32'(rdata), 32'h33);

        check_output("mem read/write exclusive", both_high, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/param_set_assoc_dcache.md
Name: param_set_assoc_dcache

Overview:
- Parametrised, write-back, write-allocate, N-way set-associative data cache.
- Next-generation replacement for the fixed direct-mapped data cache between `cpu` and `data_memory`.
- Keeps the same CPU-side and memory-side BUSYWAIT handshakes.
- Adds configurable geometry, per-set LRU replacement, a whole-cache FLUSH operation, and hit/miss counters.

Parameters:
- ADDR_W, 8, CPU byte-address width
- DATA_W, 8, CPU word width
- WORDS_PER_BLOCK, 4, words per line (power of two, ≥2)
- SETS, 8, number of sets (power of two)
- WAYS, 2, associativity (power of two, 1..8)
- CNT_W, 16, hit/miss counter width
- Derived: OFF_W=log2(WORDS_PER_BLOCK), IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W-OFF_W, BLK_W=DATA_W*WORDS_PER_BLOCK

Ports:
- CLK  in  1  system clock, all state on rising edge
- RESET  in  1  asynchronous, active-low reset
- READ  in  1  CPU read request, held until BUSYWAIT low
- WRITE  in  1  CPU write request, held until BUSYWAIT low
- ADDRESS  in  ADDR_W  CPU byte address
- WRITEDATA  in  DATA_W  CPU store data
- READDATA  out  DATA_W  load data
- BUSYWAIT  out  1  stall to CPU
- FLUSH  in  1  single-cycle request to write back all dirty lines
- FLUSH_DONE  out  1  one-cycle pulse when flush completes
- MEM_READ  out  1  block read request
- MEM_WRITE  out  1  block write request
- MEM_ADDRESS  out  ADDR_W-OFF_W  block address
- MEM_WRITEDATA  out  BLK_W  victim block
- MEM_READDATA  in  BLK_W  fill block
- MEM_BUSYWAIT  in  1  memory busy; falling edge marks completion
- HIT_COUNT  out  CNT_W  accepted hits
- MISS_COUNT  out  CNT_W  accepted misses

Behaviour:
- Address split: tag=ADDRESS[ADDR_W-1:IDX_W+OFF_W], index=next IDX_W bits, offset=low OFF_W bits.
- Per line: valid, dirty, tag, data. Per set: LRU state (true LRU; WAYS=1 has no LRU state).

Reset (RESET=0, asynchronous):
- State←IDLE.
- All valid/dirty/LRU←0.
- Counters←0.
- BUSYWAIT, MEM_READ, MEM_WRITE, FLUSH_DONE←0.
- MEM_ADDRESS, MEM_WRITEDATA←0.
- Reset mid-writeback or mid-fill abandons the transfer: memory requests drop in the same instant and no line is modified afterwards.

Handshake and hit path:
- BUSYWAIT=(READ|WRITE) & !(state==IDLE & hit), combinational; also high whenever state≠IDLE and a request is present.
- READ and WRITE both high: treated as WRITE.
- Read hit: READDATA valid in the same cycle. BUSYWAIT stays 0; LRU updated on the next edge. HIT_COUNT+1.
- READDATA=0 when there is no read hit.
- Write hit: word written, dirty←1, LRU updated on the next rising edge; zero stall cycles. HIT_COUNT+1.
- MISS_COUNT increments once per miss, on the IDLE→(WRITEBACK|ALLOCATE) edge.
- The retried access then counts as a hit.

FSM:
- IDLE:
  - Miss → victim = first invalid way (lowest index), else LRU way.
  - Victim valid & dirty → WRITEBACK, else → ALLOCATE.
  - FLUSH sampled only in IDLE with no pending request; otherwise ignored.
- WRITEBACK:
  - MEM_WRITE=1, MEM_ADDRESS={victim tag,index}, MEM_WRITEDATA=victim data.
  - Held until the first edge with MEM_BUSYWAIT=0 after assertion, then → ALLOCATE.
- ALLOCATE:
  - MEM_READ=1, MEM_ADDRESS={tag,index}.
  - On completion: line←MEM_READDATA, valid←1, dirty←0, tag written → UPDATE.
- UPDATE:
  - One cycle with no memory request → IDLE.
  - The held request now hits.
- FLUSH_SCAN:
  - Iterates set 0..SETS-1, way 0..WAYS-1.
  - Each valid & dirty line → FLUSH_WB, which behaves like WRITEBACK, clears dirty, then returns to scan.
  - Clean or invalid lines cost one cycle each.
  - After the last line: FLUSH_DONE=1 for one cycle → IDLE. Valid bits are kept.
  - Requests arriving during a flush stall until IDLE.

Arithmetic:
- Counters saturate at all-ones.
- MEM_READ and MEM_WRITE are never both high.

Test Plan (defaults; memory model has 5-cycle latency and byte n=n at reset):
- Cold READ 0x05 → MEM_READ=1, MEM_ADDRESS=0x01; BUSYWAIT low after fill+UPDATE; READDATA=0x05; MISS_COUNT=1, HIT_COUNT=1.
- WRITE 0x05 data 0xAA, then READ 0x05 → no MEM_READ/MEM_WRITE, BUSYWAIT never high; READDATA=0xAA; HIT_COUNT=3.
- Set-1 conflict on 0x05 (dirty) → READ 0x25 (fills way1) → READ 0x05 → READ 0x45:
  - Evicts way1 (clean), no MEM_WRITE.
  - Then READ 0x25 evicts way0: MEM_WRITE at MEM_ADDRESS 0x01 with byte1 of MEM_WRITEDATA=0xAA, followed by MEM_READ at 0x09.
- Dirty lines in sets 1 and 6, pulse FLUSH → exactly two MEM_WRITE transactions (addresses 0x01, 0x1E); FLUSH_DONE one pulse; later READ 0x05 hits with no memory traffic.
- RESET low during ALLOCATE cycle 2 → MEM_READ=0 immediately; after release, READ 0x05 misses again (MISS_COUNT=1).
- WAYS=1, SETS=16 rebuild → 0x05 and 0x45 conflict every access; alternating reads produce a miss every access, with no MEM_WRITE while lines are clean.
